// File: rtl/sio_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sio_fifo_ctrl
//   Autonomous sequencer between the host I/O decode and simple_sio. It polls
//   the SIO status register and drains received bytes into an RX FIFO. It also
//   feeds bytes from a TX FIFO into the SIO whenever the SIO reports tx_ready,
//   so the host never has to poll per byte.
//
// Ports
//   clk, rst          system clock (same clock as simple_sio), async active-high reset
//   en_i              1: sequencer runs; 0: finish current transaction, then hold IDLE
//   tx_push_i/din_i   host write into TX FIFO (ignored when full)
//   tx_full_o         TX FIFO full
//   tx_level_o        TX FIFO occupancy (0 .. 2**AW)
//   rx_pop_i          host read strobe from RX FIFO (ignored when empty)
//   rx_dout_o         RX FIFO head, show-ahead
//   rx_empty_o        RX FIFO empty
//   rx_overrun_o      sticky: byte received while RX FIFO full (byte dropped)
//   ovr_clr_i         clears rx_overrun_o (a simultaneous new overrun wins)
//   sio_ce_o/rd_o/wr_o/cd_o/wdata_o   strobes and data towards simple_sio
//   sio_rdata_i       simple_sio data_out (status: bit1 rx_ready, bit0 tx_ready)
// ---------------------------------------------------------------------------
module sio_fifo_ctrl #(
  parameter int AW       = 3,
  parameter int POLL_GAP = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          tx_push_i,
  input  logic [7:0]    tx_din_i,
  output logic          tx_full_o,
  output logic [AW:0]   tx_level_o,
  input  logic          rx_pop_i,
  output logic [7:0]    rx_dout_o,
  output logic          rx_empty_o,
  output logic          rx_overrun_o,
  input  logic          ovr_clr_i,
  output logic          sio_ce_o,
  output logic          sio_rd_o,
  output logic          sio_wr_o,
  output logic          sio_cd_o,
  output logic [7:0]    sio_wdata_o,
  input  logic [7:0]    sio_rdata_i
);

  localparam int         DEPTH      = 1 << AW;
  localparam logic [3:0] GAP_RELOAD = 4'(POLL_GAP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STAT_RD,
    S_STAT_CAP,
    S_DATA_RD,
    S_DATA_CAP,
    S_DATA_WR
  } state_t;

  state_t      state_q;
  logic [3:0]  gap_q;
  logic        sio_ce_q, sio_rd_q, sio_wr_q, sio_cd_q;
  logic [7:0]  sio_wdata_q;
  logic        rx_overrun_q, rx_overrun_d;

  // -------------------------------------------------------------------------
  // FIFO storage and pointers. Pointers carry one extra wrap bit so that
  // full and empty can be told apart with equal low bits.
  // -------------------------------------------------------------------------
  logic [7:0]  tx_mem [DEPTH];
  logic [7:0]  rx_mem [DEPTH];
  logic [AW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [AW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push_ok, tx_pop_ok, rx_push_ok, rx_pop_ok, rx_drop;
  logic [7:0] tx_head;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);

  // Full/empty are judged on the pre-cycle state, so a host push into a full
  // TX FIFO is dropped even while the sequencer pops, and a host pop of an
  // empty RX FIFO is dropped even while the sequencer pushes.
  assign tx_push_ok = tx_push_i && !tx_full;
  assign tx_pop_ok  = (state_q == S_DATA_WR);
  assign rx_push_ok = (state_q == S_DATA_CAP) && !rx_full;
  assign rx_drop    = (state_q == S_DATA_CAP) && rx_full;
  assign rx_pop_ok  = rx_pop_i && !rx_empty;

  assign tx_head = tx_mem[tx_rd_q[AW-1:0]];

  always_comb begin
    tx_wr_d = tx_wr_q;
    tx_rd_d = tx_rd_q;
    rx_wr_d = rx_wr_q;
    rx_rd_d = rx_rd_q;
    if (tx_push_ok) tx_wr_d = tx_wr_q + 1'b1;
    if (tx_pop_ok)  tx_rd_d = tx_rd_q + 1'b1;
    if (rx_push_ok) rx_wr_d = rx_wr_q + 1'b1;
    if (rx_pop_ok)  rx_rd_d = rx_rd_q + 1'b1;
  end

  // Set has priority over clear so an overrun is never lost.
  always_comb begin
    rx_overrun_d = rx_overrun_q;
    if (ovr_clr_i) rx_overrun_d = 1'b0;
    if (rx_drop)   rx_overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_q      <= '0;
      tx_rd_q      <= '0;
      rx_wr_q      <= '0;
      rx_rd_q      <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      tx_wr_q      <= tx_wr_d;
      tx_rd_q      <= tx_rd_d;
      rx_wr_q      <= rx_wr_d;
      rx_rd_q      <= rx_rd_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  // Memory contents need no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wr_q[AW-1:0]] <= tx_din_i;
    if (rx_push_ok) rx_mem[rx_wr_q[AW-1:0]] <= sio_rdata_i;
  end

  // -------------------------------------------------------------------------
  // Sequencer. Strobes are registered and asserted for exactly the cycle the
  // FSM spends in the matching state, so they are set on entry to that state.
  // SIO read data is valid one cycle after sio_rd, i.e. in the *_CAP states.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      sio_ce_q    <= 1'b0;
      sio_rd_q    <= 1'b0;
      sio_wr_q    <= 1'b0;
      sio_cd_q    <= 1'b0;
      sio_wdata_q <= '0;
    end else begin
      sio_ce_q <= 1'b0;
      sio_rd_q <= 1'b0;
      sio_wr_q <= 1'b0;
      sio_cd_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en_i && (gap_q == 4'd0)) begin
            state_q  <= S_STAT_RD;
            sio_ce_q <= 1'b1;
            sio_rd_q <= 1'b1;
            sio_cd_q <= 1'b1;
          end else if (gap_q != 4'd0) begin
            gap_q <= gap_q - 4'd1;
          end
        end
        S_STAT_RD: begin
          state_q <= S_STAT_CAP;
        end
        S_STAT_CAP: begin
          // Receive is served first so bursts never stall behind transmit.
          if (sio_rdata_i[1]) begin
            state_q  <= S_DATA_RD;
            sio_ce_q <= 1'b1;
            sio_rd_q <= 1'b1;
          end else if (sio_rdata_i[0] && !tx_empty) begin
            state_q     <= S_DATA_WR;
            sio_ce_q    <= 1'b1;
            sio_wr_q    <= 1'b1;
            sio_wdata_q <= tx_head;
          end else begin
            state_q <= S_IDLE;
            gap_q   <= GAP_RELOAD;
          end
        end
        S_DATA_RD: begin
          state_q <= S_DATA_CAP;
        end
        S_DATA_CAP: begin
          state_q <= S_IDLE;
          gap_q   <= GAP_RELOAD;
        end
        S_DATA_WR: begin
          state_q <= S_IDLE;
          gap_q   <= GAP_RELOAD;
        end
        default: begin
          state_q <= S_IDLE;
          gap_q   <= '0;
        end
      endcase
    end
  end

  assign tx_full_o    = tx_full;
  assign tx_level_o   = tx_wr_q - tx_rd_q;
  assign rx_dout_o    = rx_mem[rx_rd_q[AW-1:0]];
  assign rx_empty_o   = rx_empty;
  assign rx_overrun_o = rx_overrun_q;
  assign sio_ce_o     = sio_ce_q;
  assign sio_rd_o     = sio_rd_q;
  assign sio_wr_o     = sio_wr_q;
  assign sio_cd_o     = sio_cd_q;
  assign sio_wdata_o  = sio_wdata_q;

endmodule
